instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Instruction fetch front-end; consumer of the program-counter register's `o_pc` and driver of its `i_c_pc_inc`.
- Issues req/ack reads to instruction memory at the current PC and buffers returned words in a small prefetch FIFO.
- Presents {instruction, pc} to decode with a valid/ready handshake.
- Discards buffered and in-flight fetches on flush (jump/irq), since the PC is reloaded on that edge.

Parameters:
- RW, 16, address/PC width (matches `RW` from `config.v`)
- IW, 32, instruction word width
- DEPTH, 2, prefetch FIFO entries (power of 2, >= 2)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high; clock i_clk
- i_pc  in  RW  current PC from PC register
- o_c_pc_inc  out  1  PC increment strobe (one pulse per accepted fetch)
- i_flush  in  1  jump/irq this cycle; PC reloads at this edge
- o_mem_req  out  1  instruction memory read request
- o_mem_addr  out  RW  read address, stable while o_mem_req=1
- i_mem_ack  in  1  read data valid, completes the request
- i_mem_data  in  IW  read data
- o_instr  out  IW  instruction to decode
- o_instr_pc  out  RW  address of o_instr
- o_valid  out  1  o_instr valid
- i_ready  in  1  decode accepts when o_valid & i_ready

Behaviour:
- Reset values:
  - o_mem_req=0, o_mem_addr=0, o_valid=0, o_instr=0, o_instr_pc=0.
  - FIFO empty, state IDLE.
  - o_c_pc_inc=0 (combinational, gated by state).
- States:
  - IDLE: no request outstanding.
  - REQ: o_mem_req=1, waiting for ack.
  - DISCARD: request outstanding whose data must be dropped.
- IDLE->REQ when ~i_flush and (count + 0) < DEPTH.
  - o_mem_addr <= i_pc registered at the transition.
  - Request visible the next cycle.
- REQ, i_mem_ack=1, ~i_flush:
  - Push {i_mem_data, o_mem_addr} into the FIFO.
  - o_c_pc_inc=1 combinationally this cycle, so the PC advances at the edge.
  - Back-to-back: if count after push/pop < DEPTH, stay in REQ with o_mem_addr <= o_mem_addr+1 (wraps mod 2^RW); else go to IDLE.
- REQ, no ack: hold o_mem_req and o_mem_addr unchanged; no abort on the bus.
- Flush in any state: FIFO cleared, o_valid=0 next cycle, o_c_pc_inc=0 this cycle.
  - REQ with no ack in the same cycle -> DISCARD.
  - REQ with ack in the same cycle -> data dropped, go to IDLE.
  - IDLE -> stays IDLE one cycle; the new PC is visible the next cycle.
- DISCARD:
  - Keep o_mem_req=1 and the same address until ack.
  - On ack: drop data, no inc, go to IDLE.
  - Another flush while in DISCARD: stay in DISCARD.
- FIFO:
  - o_valid = ~empty.
  - Head drives o_instr/o_instr_pc.
  - Pop on o_valid & i_ready.
  - Push and pop in the same cycle are allowed when full (pop frees a slot first).
  - Never push when full: guaranteed by the issue rule count + outstanding < DEPTH.
- Latency: ack at cycle N -> o_valid at N+1 (registered FIFO).
- Throughput: 1 instr/cycle with a single-cycle-ack memory and DEPTH >= 2.
- Reset mid-request: o_mem_req drops immediately. The memory is reset by the same i_rst, so the pending ack is never produced.
- PC wrap: the address increments modulo 2^RW. Overflow signalling is owned by the PC register (o_pc_ovf qualified by inc); the fetch unit does not inspect it.

Optional Feature:
- Macro: FETCH_BYPASS_EN.
- Defined: when the FIFO is empty, an ack arrives, ~i_flush, and i_ready=1, i_mem_data/o_mem_addr drive o_instr/o_instr_pc combinationally.
  - o_valid=1 in the ack cycle; the entry is not pushed.
  - Zero-latency hit.
- Not defined: o_valid is always registered (ack N -> valid N+1). This is the default.

Decomposition:
- `RW`, `IW` and the state encoding (IDLE/REQ/DISCARD localparams) go in the shared `config.v` include.
- One sub-module: fetch_fifo.
  - Parameterized width RW+IW and DEPTH.
  - Ports: push, pop, flush, full, empty, count, data in/out.
  - Synchronous reset.

Test Plan:
- Reset, i_pc=0x0000, memory acks every cycle, i_ready=1:
  - o_mem_addr 0,1,2,3 on consecutive cycles.
  - o_valid from the cycle after the first ack.
  - o_instr_pc 0,1,2.
  - One o_c_pc_inc per ack.
- i_ready=0 with DEPTH=2:
  - After 2 acks, o_mem_req=0 and no inc; FIFO holds pc 0,1.
  - Raise i_ready: pops 0 then 1, fetching resumes at 2.
- Memory ack delayed 3 cycles: o_mem_addr stable and o_mem_req high throughout; exactly one inc on the ack cycle.
- Flush while REQ is outstanding at addr 0x0005, i_pc reloaded to 0x0100:
  - o_valid=0.
  - Ack for 0x0005 dropped with no inc.
  - Next request addr=0x0100.
- Flush coinciding with ack: data dropped, o_c_pc_inc=0, next request from the new PC.
- i_pc=0xFFFF with back-to-back acks: addresses 0xFFFF then 0x0000. With FETCH_BYPASS_EN and an empty FIFO, o_valid is high in the ack cycle.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared widths and fetch state encoding for the instruction fetch slice.
package instr_fetch_pkg;

  localparam int FETCH_RW    = 16;
  localparam int FETCH_IW    = 32;
  localparam int FETCH_DEPTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_e;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO with registered head, one-cycle flush and synchronous reset.
// Push and pop may coincide when full: the pop frees the slot the push lands in.
module fetch_fifo
  import instr_fetch_pkg::*;
#(
  parameter  int W     = FETCH_RW + FETCH_IW,
  parameter  int DEPTH = FETCH_DEPTH,
  localparam int CW    = cnt_width(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  logic [W-1:0]  i_dat,
  output logic [W-1:0]  o_dat,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_dat;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  assign o_dat   = r_mem[r_rd_ptr];
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: req/ack reads at the PC into a prefetch FIFO; {instr, pc} to decode on valid/ready.
// Ack at N gives o_valid at N+1; FETCH_BYPASS_EN lets an ack into an empty FIFO reach a ready decode at once.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int RW    = FETCH_RW,
  parameter int IW    = FETCH_IW,
  parameter int DEPTH = FETCH_DEPTH
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [RW-1:0] i_pc,
  output logic          o_c_pc_inc,
  input  logic          i_flush,
  output logic          o_mem_req,
  output logic [RW-1:0] o_mem_addr,
  input  logic          i_mem_ack,
  input  logic [IW-1:0] i_mem_data,
  output logic [IW-1:0] o_instr,
  output logic [RW-1:0] o_instr_pc,
  output logic          o_valid,
  input  logic          i_ready
);

  localparam int              CW      = cnt_width(DEPTH);
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

  fetch_state_e     r_state;
  fetch_state_e     w_state_nxt;
  logic [RW-1:0]    r_mem_addr;
  logic [RW-1:0]    w_mem_addr_nxt;
  logic             w_ack_ok;
  logic             w_bypass;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [CW-1:0]    w_count;
  logic [CW-1:0]    w_count_nxt;
  logic [RW+IW-1:0] w_head;

  // An ack only counts when it answers a live request and no flush is reloading the PC.
  assign w_ack_ok = (r_state == ST_REQ) & i_mem_ack & ~i_flush;

`ifdef FETCH_BYPASS_EN
  assign w_bypass = w_ack_ok & w_empty & i_ready;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push      = w_ack_ok & ~w_bypass;
  assign w_pop       = ~w_empty & i_ready;
  assign w_count_nxt = w_count + CW'(w_push) - CW'(w_pop);
  assign o_c_pc_inc  = w_ack_ok;

  always_comb begin
    w_state_nxt    = r_state;
    w_mem_addr_nxt = r_mem_addr;
    case (r_state)
      ST_IDLE: begin
        if (!i_flush && !w_full) begin
          w_state_nxt    = ST_REQ;
          w_mem_addr_nxt = i_pc;
        end
      end
      ST_REQ: begin
        if (i_mem_ack) begin
          if (i_flush)                     w_state_nxt    = ST_IDLE;
          else if (w_count_nxt < DEPTH_C)  w_mem_addr_nxt = r_mem_addr + RW'(1);
          else                             w_state_nxt    = ST_IDLE;
        end else if (i_flush) begin
          w_state_nxt = ST_DISCARD;
        end
      end
      ST_DISCARD: begin
        if (i_mem_ack) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_mem_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_mem_addr <= w_mem_addr_nxt;
    end
  end

  assign o_mem_req  = (r_state != ST_IDLE);
  assign o_mem_addr = r_mem_addr;

  fetch_fifo #(
    .W     (RW + IW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (i_flush),
    .i_dat   ({i_mem_data, r_mem_addr}),
    .o_dat   (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign o_valid                = ~w_empty | w_bypass;
  assign {o_instr, o_instr_pc}  = w_bypass ? {i_mem_data, r_mem_addr} : w_head;

endmodule

// File: tb/tb_instr_fetch.sv
// Randomised bench for instr_fetch: memory responder, PC register and in-order instruction scoreboard.
module tb_instr_fetch;

`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [15:0] pc;
  logic        pc_inc;
  logic        flush;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic [31:0] instr;
  logic [15:0] instr_pc;
  logic        valid;
  logic        ready;

  int n_pass = 0;
  int n_total = 0;

  // Reference model state
  logic [15:0] m_pc;
  logic [47:0] exp_q[$];
  bit          stale, pend, req_active, lat_rand;
  logic [15:0] pend_addr;
  int          wait_cnt, lat_cfg, lat_max;
  int          n_ack, n_acc, n_hs;

  // Per-cycle observations
  logic        s_req, s_vld, s_inc, s_ack;
  logic [15:0] s_addr, s_ipc;

  instr_fetch dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_pc       (pc),
    .o_c_pc_inc (pc_inc),
    .i_flush    (flush),
    .o_mem_req  (mem_req),
    .o_mem_addr (mem_addr),
    .i_mem_ack  (mem_ack),
    .i_mem_data (mem_data),
    .o_instr    (instr),
    .o_instr_pc (instr_pc),
    .o_valid    (valid),
    .i_ready    (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {~a, a ^ 16'h5A3C};
  endfunction

  // One cycle, entered and left at a falling edge: drive, sample, score, advance the PC model.
  task automatic tick(input bit fl, input bit rdy, input logic [15:0] tgt);
    bit          ack_now, acc, byp, exp_vld;
    logic [47:0] item;
    pc = m_pc;
    ack_now = 1'b0;
    if (mem_req === 1'b1) begin
      if (!req_active) begin
        req_active = 1'b1;
        wait_cnt = lat_rand ? int'($urandom_range(lat_max, 0)) : lat_cfg;
      end
      if (wait_cnt == 0) ack_now = 1'b1;
      else wait_cnt--;
    end
    mem_ack  = ack_now;
    mem_data = ack_now ? mem_word(mem_addr) : $urandom();
    flush    = fl;
    ready    = rdy;
    #1;
    s_req = mem_req; s_addr = mem_addr; s_vld = valid; s_ipc = instr_pc; s_inc = pc_inc; s_ack = ack_now;

    acc = ack_now && !stale && !fl;
    n_total++;
    if (pc_inc !== acc) $display("FAIL inc t=%0t got=%b exp=%b", $time, pc_inc, acc);
    else n_pass++;
    if (acc) begin
      n_total++;
      if (mem_addr !== m_pc) $display("FAIL ack_addr t=%0t got=%h exp=%h", $time, mem_addr, m_pc);
      else n_pass++;
    end
    if (pend) begin
      n_total++;
      if (mem_req !== 1'b1 || mem_addr !== pend_addr)
        $display("FAIL req_hold t=%0t got=%b/%h exp=1/%h", $time, mem_req, mem_addr, pend_addr);
      else n_pass++;
    end

    byp = BYP && acc && rdy && (exp_q.size() == 0);
    exp_vld = (exp_q.size() != 0) || byp;
    n_total++;
    if (valid !== exp_vld) $display("FAIL valid t=%0t got=%b exp=%b", $time, valid, exp_vld);
    else n_pass++;
    if (exp_vld && rdy) begin
      item = byp ? {mem_word(m_pc), m_pc} : exp_q.pop_front();
      n_total++;
      if ({instr, instr_pc} !== item)
        $display("FAIL deliver t=%0t got=%h/%h exp=%h/%h", $time, instr, instr_pc, item[47:16], item[15:0]);
      else n_pass++;
      n_hs++;
    end
    if (acc && !byp) exp_q.push_back({mem_word(m_pc), m_pc});
    if (fl) exp_q.delete();

    if (ack_now) begin
      stale = 1'b0;
      req_active = 1'b0;
      n_ack++;
    end else if (fl && mem_req) begin
      stale = 1'b1;
    end
    pend = mem_req && !ack_now;
    pend_addr = mem_addr;
    if (acc) n_acc++;
    if (fl) m_pc = tgt;
    else if (acc) m_pc = m_pc + 16'd1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [15:0] start);
    rst = 1'b1; mem_ack = 1'b0; flush = 1'b0; ready = 1'b0; pc = start;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_pc = start; exp_q.delete();
    stale = 1'b0; pend = 1'b0; req_active = 1'b0;
    lat_rand = 1'b0; lat_cfg = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; pc = 16'h1234; mem_ack = 1'b1; mem_data = 32'hDEADBEEF; flush = 1'b0; ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_total++; if (mem_req !== 1'b0)  $display("FAIL rst_req got=%b exp=0", mem_req); else n_pass++;
    n_total++; if (mem_addr !== 16'h0) $display("FAIL rst_addr got=%h exp=0", mem_addr); else n_pass++;
    n_total++; if (valid !== 1'b0)    $display("FAIL rst_valid got=%b exp=0", valid); else n_pass++;
    n_total++; if (instr !== 32'h0)   $display("FAIL rst_instr got=%h exp=0", instr); else n_pass++;
    n_total++; if (instr_pc !== 16'h0) $display("FAIL rst_ipc got=%h exp=0", instr_pc); else n_pass++;
    n_total++; if (pc_inc !== 1'b0)   $display("FAIL rst_inc got=%b exp=0", pc_inc); else n_pass++;
    // Reset while a request waits on a slow memory
    rst = 1'b0; mem_ack = 1'b0; m_pc = 16'h0010; exp_q.delete();
    stale = 1'b0; pend = 1'b0; req_active = 1'b0; lat_rand = 1'b0; lat_cfg = 10;
    tick(0, 0, 16'h0);
    tick(0, 0, 16'h0);
    n_total++; if (s_req !== 1'b1) $display("FAIL pre_rst_req got=%b exp=1", s_req); else n_pass++;
    rst = 1'b1; mem_ack = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_total++; if (mem_req !== 1'b0) $display("FAIL mid_rst_req got=%b exp=0", mem_req); else n_pass++;
  endtask

  task automatic test_stream();
    int a0;
    logic [15:0] exp_ipc;
    do_reset(16'h0000);
    tick(0, 1, 16'h0);
    n_total++; if (s_req !== 1'b0) $display("FAIL stream_idle got=%b exp=0", s_req); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      tick(0, 1, 16'h0);
      n_total++;
      if (s_req !== 1'b1 || s_addr !== 16'(i)) $display("FAIL stream_addr got=%b/%h exp=1/%h", s_req, s_addr, 16'(i));
      else n_pass++;
      n_total++;
      if (s_vld !== ((i > 0) || BYP)) $display("FAIL stream_valid i=%0d got=%b exp=%b", i, s_vld, (i > 0) || BYP);
      else n_pass++;
      exp_ipc = BYP ? 16'(i) : 16'(i - 1);
      if (i > 0 || BYP) begin
        n_total++;
        if (s_ipc !== exp_ipc) $display("FAIL stream_ipc got=%h exp=%h", s_ipc, exp_ipc); else n_pass++;
      end
    end
    a0 = n_acc;
    repeat (16) tick(0, 1, 16'h0);
    n_total++;
    if (n_acc - a0 != 16) $display("FAIL stream_rate got=%0d exp=16", n_acc - a0); else n_pass++;
  endtask

  task automatic test_backpressure();
    int  k0;
    bit  got;
    do_reset(16'h0000);
    k0 = n_ack;
    repeat (6) tick(0, 0, 16'h0);
    n_total++; if (n_ack - k0 != 2) $display("FAIL bp_acks got=%0d exp=2", n_ack - k0); else n_pass++;
    n_total++; if (s_req !== 1'b0 || s_inc !== 1'b0) $display("FAIL bp_idle got=%b/%b exp=0/0", s_req, s_inc); else n_pass++;
    n_total++; if (s_vld !== 1'b1 || s_ipc !== 16'h0) $display("FAIL bp_head got=%b/%h exp=1/0000", s_vld, s_ipc); else n_pass++;
    tick(0, 1, 16'h0);
    n_total++; if (s_ipc !== 16'h0) $display("FAIL bp_pop0 got=%h exp=0000", s_ipc); else n_pass++;
    tick(0, 1, 16'h0);
    n_total++; if (s_ipc !== 16'h1) $display("FAIL bp_pop1 got=%h exp=0001", s_ipc); else n_pass++;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      tick(0, 1, 16'h0);
      if (s_req) got = 1'b1;
    end
    n_total++;
    if (!got || s_addr !== 16'h2) $display("FAIL bp_resume got=%b/%h exp=1/0002", got, s_addr); else n_pass++;
  endtask

  task automatic test_slow_ack();
    int nreq, ninc;
    bit got;
    do_reset(16'h0040);
    lat_cfg = 3;
    nreq = 0; ninc = 0; got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick(0, 1, 16'h0);
      if (s_req) nreq++;
      if (s_inc) ninc++;
      if (s_ack) got = 1'b1;
    end
    n_total++; if (!got) $display("FAIL slow_timeout got=0 exp=1"); else n_pass++;
    n_total++; if (nreq != 4) $display("FAIL slow_req_cycles got=%0d exp=4", nreq); else n_pass++;
    n_total++; if (ninc != 1 || s_inc !== 1'b1) $display("FAIL slow_inc got=%0d/%b exp=1/1", ninc, s_inc); else n_pass++;
    n_total++; if (s_addr !== 16'h0040) $display("FAIL slow_addr got=%h exp=0040", s_addr); else n_pass++;
  endtask

  task automatic test_flush_outstanding();
    bit got;
    do_reset(16'h0004);
    tick(0, 0, 16'h0);
    tick(0, 0, 16'h0);
    n_total++; if (s_ack !== 1'b1 || s_addr !== 16'h4) $display("FAIL fo_first got=%b/%h exp=1/0004", s_ack, s_addr); else n_pass++;
    lat_cfg = 3;
    tick(0, 0, 16'h0);
    n_total++; if (s_req !== 1'b1 || s_addr !== 16'h5 || s_ack) $display("FAIL fo_wait got=%b/%h exp=1/0005", s_req, s_addr); else n_pass++;
    tick(1, 0, 16'h0100);
    n_total++; if (s_inc !== 1'b0 || s_vld !== 1'b1) $display("FAIL fo_flush got=%b/%b exp=0/1", s_inc, s_vld); else n_pass++;
    tick(0, 1, 16'h0);
    n_total++; if (s_vld !== 1'b0) $display("FAIL fo_valid got=%b exp=0", s_vld); else n_pass++;
    n_total++; if (s_req !== 1'b1 || s_addr !== 16'h5) $display("FAIL fo_discard got=%b/%h exp=1/0005", s_req, s_addr); else n_pass++;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick(0, 1, 16'h0);
      if (s_ack) got = 1'b1;
    end
    n_total++; if (!got || s_inc !== 1'b0) $display("FAIL fo_drop got=%b/%b exp=1/0", got, s_inc); else n_pass++;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick(0, 1, 16'h0);
      if (s_req) got = 1'b1;
    end
    n_total++; if (!got || s_addr !== 16'h0100) $display("FAIL fo_newpc got=%b/%h exp=1/0100", got, s_addr); else n_pass++;
  endtask

  task automatic test_flush_with_ack();
    do_reset(16'h0020);
    repeat (4) tick(0, 1, 16'h0);
    n_total++; if (s_req !== 1'b1) $display("FAIL fa_stream got=%b exp=1", s_req); else n_pass++;
    tick(1, 1, 16'h0300);
    n_total++; if (s_ack !== 1'b1 || s_inc !== 1'b0) $display("FAIL fa_drop got=%b/%b exp=1/0", s_ack, s_inc); else n_pass++;
    tick(0, 1, 16'h0);
    n_total++; if (s_vld !== 1'b0 || s_req !== 1'b0) $display("FAIL fa_idle got=%b/%b exp=0/0", s_vld, s_req); else n_pass++;
    tick(0, 1, 16'h0);
    n_total++; if (s_req !== 1'b1 || s_addr !== 16'h0300) $display("FAIL fa_newpc got=%b/%h exp=1/0300", s_req, s_addr); else n_pass++;
  endtask

  task automatic test_wrap();
    do_reset(16'hFFFF);
    tick(0, 1, 16'h0);
    tick(0, 1, 16'h0);
    n_total++; if (s_ack !== 1'b1 || s_addr !== 16'hFFFF) $display("FAIL wrap_first got=%b/%h exp=1/ffff", s_ack, s_addr); else n_pass++;
    n_total++; if (s_vld !== BYP) $display("FAIL wrap_valid got=%b exp=%b", s_vld, BYP); else n_pass++;
    tick(0, 1, 16'h0);
    n_total++; if (s_addr !== 16'h0000) $display("FAIL wrap_next got=%h exp=0000", s_addr); else n_pass++;
  endtask

  task automatic test_random();
    int h0;
    bit fl, rdy;
    do_reset(16'($urandom()));
    lat_rand = 1'b1;
    lat_max = 0;
    h0 = n_hs;
    for (int i = 0; i < 1000; i++) begin
      if (i == 400) lat_max = 3;
      fl  = ($urandom_range(19, 0) == 0);
      rdy = ($urandom_range(3, 0) != 0);
      tick(fl, rdy, 16'($urandom()));
    end
    n_total++; if (n_hs - h0 < 100) $display("FAIL rand_progress got=%0d exp>=100", n_hs - h0); else n_pass++;
  endtask

  initial begin
    n_ack = 0; n_acc = 0; n_hs = 0; lat_max = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_slow_ack();
    test_flush_outstanding();
    test_flush_with_ack();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
